// File: rtl/c2_pipe_addsub.sv
// c2_pipe_addsub: pipelined two's-complement adder/subtractor.
// Carry chain is cut into STAGES chunks; global-enable valid/ready shift.
module c2_pipe_addsub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int CHUNK = WIDTH / STAGES;

   logic             r_v  [STAGES];
   logic [WIDTH-1:0] r_a  [STAGES];
   logic [WIDTH-1:0] r_b  [STAGES];
   logic [WIDTH-1:0] r_s  [STAGES];
   logic             r_c  [STAGES];
   logic [WIDTH-1:0] w_s  [STAGES];
   logic             w_co [STAGES];
   logic             w_adv;

   assign w_adv    = !r_v[STAGES-1] || out_ready;
   assign in_ready = w_adv;

   // Stage k finishes slice k of the sum and hands its carry onward.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK:0]   w_cy;
      logic [CHUNK-1:0] w_sl;
      logic [WIDTH-1:0] w_snx;

      always_comb begin
         logic w_x;
         logic w_y;
         w_cy    = '0;
         w_cy[0] = r_c[k];
         w_sl    = '0;
         for (int i = 0; i < CHUNK; i++) begin
            w_x       = r_a[k][k*CHUNK+i];
            w_y       = r_b[k][k*CHUNK+i];
            w_sl[i]   = w_x ^ w_y ^ w_cy[i];
            w_cy[i+1] = (w_x & w_y) |
                        (w_x & w_cy[i]) |
                        (w_y & w_cy[i]);
         end
      end

      always_comb begin
         w_snx = r_s[k];
         w_snx[k*CHUNK +: CHUNK] = w_sl;
      end

      assign w_s[k]  = w_snx;
      assign w_co[k] = w_cy[CHUNK];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_v[k] <= 1'b0;
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
      end else if (w_adv) begin
         r_v[0] <= in_valid;
         r_a[0] <= a;
         r_b[0] <= b ^ {WIDTH{sub}};
         r_s[0] <= '0;
         r_c[0] <= sub;
         for (int k = 1; k < STAGES; k++) begin
            r_v[k] <= r_v[k-1];
            r_a[k] <= r_a[k-1];
            r_b[k] <= r_b[k-1];
            r_s[k] <= w_s[k-1];
            r_c[k] <= w_co[k-1];
         end
      end
   end

   // Last stage is combinational off held registers, so a stall freezes it.
   assign out_valid = r_v[STAGES-1];
   assign sum       = w_s[STAGES-1];
   assign cout      = w_co[STAGES-1];
   assign ovf       = g_stage[STAGES-1].w_cy[CHUNK-1]
                    ^ w_co[STAGES-1];

endmodule

// File: tb/tb_c2_pipe_addsub.sv
// Self-checking bench for c2_pipe_addsub (WIDTH=16, STAGES=4).
// Expected results are queued on acceptance and compared on output handshake.
module tb_c2_pipe_addsub;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int checks  = 0;
   int errors  = 0;
   int pop_cnt = 0;
   int cyc     = 0;
   logic [17:0] sb [$];
   int pop_cyc [$];
   logic [17:0] exp_r;

   c2_pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [17:0] model(input logic [15:0] ia,
                                         input logic [15:0] ib,
                                         input logic isub);
      logic [15:0] bb;
      logic [16:0] f;
      logic o;
      bb = isub ? ~ib : ib;
      f  = {1'b0, ia} + {1'b0, bb} + {16'b0, isub};
      o  = (ia[15] == bb[15]) && (f[15] != ia[15]);
      return {f[15:0], f[16], o};
   endfunction

   // Scoreboard: compare each retired result against the queue head.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_output: sum=%h cout=%b ovf=%b, required none",
                     sum, cout, ovf);
         end else begin
            exp_r = sb.pop_front();
            pop_cnt++;
            pop_cyc.push_back(cyc);
            if ({sum, cout, ovf} !== exp_r) begin
               errors++;
               $display("FAIL result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                        sum, cout, ovf, exp_r[17:2], exp_r[1], exp_r[0]);
            end
         end
      end
   end

   task automatic send(input logic [15:0] ia, input logic [15:0] ib,
                       input logic isub, input logic [17:0] ex,
                       output int stalls);
      int n;
      stalls = 0;
      n = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a = ia;
      b = ib;
      sub = isub;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            sb.push_back(ex);
            break;
         end
         stalls++;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1",
                     in_ready, n);
            break;
         end
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'hxxxx;
      b = 16'hxxxx;
      sub = 1'bx;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d outstanding, required 0", tag, sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, sum, cout, ovf} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b sum=%h cout=%b ovf=%b, required all 0",
                  out_valid, sum, cout, ovf);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_wrap();
      int st;
      int cnt;
      send(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0}, st);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 10) begin
         @(posedge clk);
         cnt++;
         #1;
      end
      checks++;
      if (cnt != 3) begin
         errors++;
         $display("FAIL latency: out_valid after %0d edges past capture, required 3",
                  cnt);
      end
      drain("add_wrap");
   endtask

   task automatic test_overflow();
      int st;
      send(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1}, st);
      send(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b1}, st);
      idle();
      drain("overflow");
   endtask

   task automatic test_borrow();
      int st;
      send(16'h0005, 16'h0007, 1'b1, {16'hFFFE, 1'b0, 1'b0}, st);
      send(16'h1234, 16'h1234, 1'b1, {16'h0000, 1'b1, 1'b0}, st);
      idle();
      drain("borrow");
   endtask

   task automatic test_bubble_x();
      idle();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bubble_valid: got %b, required 0", out_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      int st;
      int tot;
      int base;
      logic [15:0] ra;
      logic [15:0] rb;
      logic rs;
      tot = 0;
      base = pop_cnt;
      for (int i = 0; i < 64; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         send(ra, rb, rs, model(ra, rb, rs), st);
         tot += st;
      end
      idle();
      drain("stream");
      checks++;
      if (tot != 0) begin
         errors++;
         $display("FAIL stream_in_ready: %0d stall cycles, required 0", tot);
      end
      checks++;
      if (pop_cnt - base != 64) begin
         errors++;
         $display("FAIL stream_count: %0d results, required 64", pop_cnt - base);
      end else begin
         checks++;
         if (pop_cyc[base+63] - pop_cyc[base] != 63) begin
            errors++;
            $display("FAIL stream_rate: 64 results over %0d cycles, required 63",
                     pop_cyc[base+63] - pop_cyc[base]);
         end
      end
   endtask

   task automatic test_backpressure();
      int base;
      logic [17:0] snap;
      base = pop_cnt;
      fork
         begin
            int st;
            logic [15:0] ra;
            logic [15:0] rb;
            logic rs;
            for (int i = 0; i < 12; i++) begin
               ra = 16'($urandom);
               rb = 16'($urandom);
               rs = 1'($urandom);
               send(ra, rb, rs, model(ra, rb, rs), st);
            end
            idle();
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            out_ready = 1'b0;
            snap = {sum, cout, ovf};
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               checks++;
               if (in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_in_ready: got %b, required 0", in_ready);
               end
               checks++;
               if (out_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL stall_valid: got %b, required 1", out_valid);
               end
               checks++;
               if ({sum, cout, ovf} !== snap) begin
                  errors++;
                  $display("FAIL stall_hold: got %h, required %h",
                           {sum, cout, ovf}, snap);
               end
               @(posedge clk);
            end
            #1;
            out_ready = 1'b1;
         end
      join
      drain("backpressure");
      checks++;
      if (pop_cnt - base != 12) begin
         errors++;
         $display("FAIL bp_count: %0d results, required 12", pop_cnt - base);
      end
   endtask

   task automatic test_reset_midflight();
      int st;
      int n;
      logic seen;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0), st);
      send(16'h0F0F, 16'h0101, 1'b0, model(16'h0F0F, 16'h0101, 1'b0), st);
      send(16'h4000, 16'h0001, 1'b1, model(16'h4000, 16'h0001, 1'b1), st);
      idle();
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset: valid=%b sum=%h, required 0 0000",
                  out_valid, sum);
      end
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL stale_after_reset: out_valid seen 1, required 0");
      end
      send(16'h0100, 16'h00FF, 1'b0, {16'h01FF, 1'b0, 1'b0}, st);
      idle();
      drain("post_reset");
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      sub = 1'b0;
      test_reset();
      test_add_wrap();
      test_overflow();
      test_borrow();
      test_bubble_x();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
